pwm_sweep_ctrl: RTL and testbench

Sequencer that drives the PWM generator through a stepped brightness sweep for the light-measurement path. On start it programs each duty level in turn (0, step, 2·step, … up to full scale) and holds every level for a programmable number of PWM periods so the sensor settles. It then requests one measurement over a req/ack handshake and advances to the next level. At the end, or on abort, it writes duty 0 to switch the light off.

---
 rtl/pwm_ctrl_pkg.sv | 23 ++
 rtl/pwm_period_cnt.sv | 39 +++
 rtl/pwm_sweep_ctrl.sv | 127 ++++++++++++
 tb/tb_pwm_sweep_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// rtl/pwm_ctrl_pkg.sv - shared state encoding and PWM period constants for the sweep controller
package pwm_ctrl_pkg;

  localparam int DEF_SIZE_OF_VALUE = 8;

  // One PWM period spans every code of the duty counter.
  function automatic int period_len(input int size_of_value);
    return 1 << size_of_value;
  endfunction

  localparam int DEF_PERIOD_LEN = 1 << DEF_SIZE_OF_VALUE;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_NEXT    = 3'd4,
    ST_FINISH  = 3'd5,
    ST_OFF     = 3'd6
  } sweep_state_e;

endpackage

// File: rtl/pwm_period_cnt.sv
// rtl/pwm_period_cnt.sv - clock and PWM-period counters with a one-cycle settle terminal pulse
module pwm_period_cnt
  import pwm_ctrl_pkg::*;
#(
  parameter int SIZE_OF_VALUE = DEF_SIZE_OF_VALUE,
  parameter int SETTLE_W      = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [SETTLE_W-1:0] target_i,
  output logic                term_o
);

  logic [SIZE_OF_VALUE-1:0] clk_cnt_q;
  logic [SETTLE_W-1:0]      per_cnt_q;
  logic [SETTLE_W-1:0]      target_m1;
  logic                     clk_wrap;

  assign clk_wrap  = &clk_cnt_q;
  assign target_m1 = target_i - {{(SETTLE_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      clk_cnt_q <= '0;
      per_cnt_q <= '0;
    end else if (en_i) begin
      clk_cnt_q <= clk_cnt_q + {{(SIZE_OF_VALUE-1){1'b0}}, 1'b1};
      if (clk_wrap) begin
        per_cnt_q <= per_cnt_q + {{(SETTLE_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Fires on the last clock of the last settle period.
  assign term_o = en_i && clk_wrap && (per_cnt_q == target_m1);

endmodule

// File: rtl/pwm_sweep_ctrl.sv
// rtl/pwm_sweep_ctrl.sv - stepped PWM brightness sweep with per-level settle and measurement handshake
module pwm_sweep_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int SIZE_OF_VALUE = DEF_SIZE_OF_VALUE,
  parameter int SETTLE_W      = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [SIZE_OF_VALUE-1:0] step_i,
  input  logic [SETTLE_W-1:0]      settle_i,
  output logic                     pwm_set_o,
  output logic [SIZE_OF_VALUE-1:0] pwm_value_o,
  output logic                     meas_req_o,
  input  logic                     meas_ack_i,
  output logic                     busy_o,
  output logic                     done_o
);

  sweep_state_e state_q, state_d;

  logic [SIZE_OF_VALUE-1:0] level_q;
  logic [SIZE_OF_VALUE-1:0] step_q;
  logic [SIZE_OF_VALUE-1:0] last_val_q;
  logic [SIZE_OF_VALUE-1:0] value_c;
  logic [SETTLE_W-1:0]      settle_q;
  logic [SIZE_OF_VALUE:0]   sum_c;
  logic                     sweep_end_c;
  logic                     cnt_clr;
  logic                     cnt_en;
  logic                     period_term;
  logic                     start_acc;

  // One extra bit so an overshoot past full scale is seen, never wrapped.
  assign sum_c       = {1'b0, level_q} + {1'b0, step_q};
  assign sweep_end_c = (step_q == '0) || sum_c[SIZE_OF_VALUE];
  assign start_acc   = (state_q == ST_IDLE) && start_i;

  pwm_period_cnt #(
    .SIZE_OF_VALUE (SIZE_OF_VALUE),
    .SETTLE_W      (SETTLE_W)
  ) u_period_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .target_i (settle_q),
    .term_o   (period_term)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_i) state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_SETTLE;
      ST_SETTLE:  if (period_term) state_d = ST_MEASURE;
      ST_MEASURE: if (meas_ack_i) state_d = ST_NEXT;
      ST_NEXT:    state_d = sweep_end_c ? ST_FINISH : ST_LOAD;
      ST_FINISH:  state_d = ST_IDLE;
      ST_OFF:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // Abort overrides everything in the active states, including an ack.
    if (abort_i && (state_q inside {ST_LOAD, ST_SETTLE, ST_MEASURE, ST_NEXT})) begin
      state_d = ST_OFF;
    end
  end

  always_comb begin
    pwm_set_o  = 1'b0;
    value_c    = '0;
    meas_req_o = 1'b0;
    done_o     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    busy_o     = (state_q != ST_IDLE);
    case (state_q)
      ST_LOAD: begin
        pwm_set_o = 1'b1;
        value_c   = level_q;
        cnt_clr   = 1'b1;
      end
      ST_SETTLE:  cnt_en = 1'b1;
      ST_MEASURE: meas_req_o = 1'b1;
      ST_FINISH: begin
        pwm_set_o = 1'b1;
        done_o    = 1'b1;
      end
      ST_OFF:     pwm_set_o = 1'b1;
      default: ;
    endcase
  end

  assign pwm_value_o = pwm_set_o ? value_c : last_val_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q    <= '0;
      step_q     <= '0;
      settle_q   <= '0;
      last_val_q <= '0;
    end else begin
      if (start_acc) begin
        level_q  <= '0;
        step_q   <= step_i;
        settle_q <= (settle_i == '0) ? {{(SETTLE_W-1){1'b0}}, 1'b1} : settle_i;
      end
      if ((state_q == ST_NEXT) && (state_d == ST_LOAD)) begin
        level_q <= sum_c[SIZE_OF_VALUE-1:0];
      end
      if (pwm_set_o) begin
        last_val_q <= value_c;
      end
    end
  end

endmodule

// File: tb/tb_pwm_sweep_ctrl.sv
// tb/tb_pwm_sweep_ctrl.sv - directed self-checking bench for pwm_sweep_ctrl at SIZE_OF_VALUE=4
module tb_pwm_sweep_ctrl;

  localparam int SV = 4;
  localparam int SW = 16;

  logic          clk_i    = 1'b0;
  logic          rst_i    = 1'b1;
  logic          start_i  = 1'b0;
  logic          abort_i  = 1'b0;
  logic [SV-1:0] step_i   = '0;
  logic [SW-1:0] settle_i = '0;
  logic          pwm_set_o;
  logic [SV-1:0] pwm_value_o;
  logic          meas_req_o;
  logic          meas_ack_i;
  logic          busy_o;
  logic          done_o;

  logic auto_ack   = 1'b1;
  logic auto_ack_v = 1'b0;
  logic man_ack    = 1'b0;
  assign meas_ack_i = auto_ack ? auto_ack_v : man_ack;

  pwm_sweep_ctrl #(.SIZE_OF_VALUE(SV), .SETTLE_W(SW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .step_i      (step_i),
    .settle_i    (settle_i),
    .pwm_set_o   (pwm_set_o),
    .pwm_value_o (pwm_value_o),
    .meas_req_o  (meas_req_o),
    .meas_ack_i  (meas_ack_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic [SV-1:0] set_val [64];
  int            set_cyc [64];
  int            req_cyc [64];
  int            set_n = 0, req_n = 0, done_n = 0;
  int            done_cyc = 0, busy_fall_cyc = 0, req_age = 0;
  logic          req_prev = 1'b0, busy_prev = 1'b0;
  int            n_cmp = 0, n_err = 0;

  // Event log plus the automatic acker (ack in the second request cycle).
  always @(negedge clk_i) begin
    if (pwm_set_o && set_n < 64) begin
      set_val[set_n] = pwm_value_o;
      set_cyc[set_n] = cyc;
      set_n++;
    end
    if (meas_req_o && !req_prev && req_n < 64) begin
      req_cyc[req_n] = cyc;
      req_n++;
    end
    if (done_o) begin
      done_n++;
      done_cyc = cyc;
    end
    if (busy_prev && !busy_o) busy_fall_cyc = cyc;
    req_prev  = meas_req_o;
    busy_prev = busy_o;
    if (meas_req_o) begin
      auto_ack_v = (req_age == 1);
      req_age++;
    end else begin
      auto_ack_v = 1'b0;
      req_age    = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_sweep(input logic [SV-1:0] st, input logic [SW-1:0] se, output int s);
    @(negedge clk_i);
    step_i   = st;
    settle_i = se;
    start_i  = 1'b1;
    s        = cyc;
    @(negedge clk_i);
    start_i  = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int k;
    k = 0;
    while (!meas_req_o && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    check(tag, meas_req_o, 1);
  endtask

  task automatic run_sweep(input logic [SV-1:0] st, input logic [SW-1:0] se,
                           input logic [31:0] exp_vals, input int exp_n,
                           input int req_lat, input int lvl_gap);
    int s, bs, br, bd, k;
    bs = set_n;
    br = req_n;
    bd = done_n;
    start_sweep(st, se, s);
    k = 0;
    while (busy_o && k < 3000) begin
      @(negedge clk_i);
      k++;
    end
    check("sweep_timeout", k < 3000, 1);
    repeat (2) @(negedge clk_i);
    check("n_writes", set_n - bs, exp_n);
    for (int i = 0; i < exp_n; i++) begin
      check("write_val", set_val[bs+i], exp_vals[4*i +: 4]);
    end
    check("n_reqs", req_n - br, exp_n - 1);
    check("load_lat", set_cyc[bs] - s, 1);
    check("req_lat", req_cyc[br] - set_cyc[bs], req_lat);
    check("lvl_gap", set_cyc[bs+1] - set_cyc[bs], lvl_gap);
    check("done_cnt", done_n - bd, 1);
    check("done_on_last", done_cyc, set_cyc[bs+exp_n-1]);
    check("busy_fall", busy_fall_cyc - done_cyc, 1);
  endtask

  initial begin
    int s, bs, bd, k, bad;

    repeat (3) @(negedge clk_i);
    check("rst_set", pwm_set_o, 0);
    check("rst_val", pwm_value_o, 0);
    check("rst_req", meas_req_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    rst_i = 1'b0;

    // Reset during the second level's settle.
    bs = set_n;
    start_sweep(4'd5, 16'd1, s);
    k = 0;
    while ((set_n - bs) < 2 && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    check("rst_reach_lvl1", (set_n - bs) >= 2, 1);
    repeat (6) @(negedge clk_i);
    check("rst_pre_val", pwm_value_o, 5);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("mid_rst_set", pwm_set_o, 0);
    check("mid_rst_val", pwm_value_o, 0);
    check("mid_rst_req", meas_req_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_done", done_o, 0);
    bs = set_n;
    repeat (40) @(negedge clk_i);
    check("rst_quiet", set_n - bs, 0);

    // Writes 0,5,10,15,0 ; 0,6,12,0 ; 0,0 (settle 0 acts as 1).
    run_sweep(4'd5, 16'd1, 32'h0000_FA50, 5, 17, 20);
    run_sweep(4'd6, 16'd2, 32'h0000_0C60, 4, 33, 36);
    run_sweep(4'd0, 16'd0, 32'h0000_0000, 2, 17, 20);

    // Ack during settle and start while busy are ignored; ack withheld; abort in MEASURE.
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    bs = set_n;
    bd = done_n;
    start_sweep(4'd5, 16'd1, s);
    repeat (2) @(negedge clk_i);
    man_ack = 1'b1;
    start_i = 1'b1;
    step_i  = 4'd1;
    repeat (3) @(negedge clk_i);
    man_ack = 1'b0;
    start_i = 1'b0;
    wait_req("req_seen_a");
    check("busy_start_ignored", set_n - bs, 1);
    check("req_lat_ack_ignored", cyc - set_cyc[bs], 17);
    bad = 0;
    repeat (50) begin
      @(negedge clk_i);
      if (!meas_req_o || pwm_set_o) bad++;
    end
    check("req_held", bad, 0);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("abort_set", pwm_set_o, 1);
    check("abort_val", pwm_value_o, 0);
    check("abort_done", done_o, 0);
    check("abort_req", meas_req_o, 0);
    @(negedge clk_i);
    check("abort_idle", busy_o, 0);
    check("abort_set_end", pwm_set_o, 0);
    check("abort_no_done", done_n - bd, 0);

    // start+abort together in IDLE starts; abort in the ack cycle turns the light off.
    bs = set_n;
    @(negedge clk_i);
    step_i   = 4'd5;
    settle_i = 16'd1;
    start_i  = 1'b1;
    abort_i  = 1'b1;
    @(negedge clk_i);
    start_i  = 1'b0;
    abort_i  = 1'b0;
    check("start_abort_load", pwm_set_o, 1);
    @(negedge clk_i);
    check("start_abort_busy", busy_o, 1);
    wait_req("req_seen_b");
    man_ack = 1'b1;
    abort_i = 1'b1;
    @(negedge clk_i);
    man_ack = 1'b0;
    abort_i = 1'b0;
    check("ackabort_set", pwm_set_o, 1);
    check("ackabort_val", pwm_value_o, 0);
    check("ackabort_done", done_o, 0);
    check("ackabort_req", meas_req_o, 0);
    @(negedge clk_i);
    check("ackabort_idle", busy_o, 0);
    abort_i = 1'b1;
    repeat (3) @(negedge clk_i);
    abort_i = 1'b0;
    check("idle_abort_busy", busy_o, 0);
    check("idle_abort_set", pwm_set_o, 0);
    repeat (2) @(negedge clk_i);
    check("ackabort_writes", set_n - bs, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
